// File: rtl/mux16_sched_pkg.sv
// Shared types and the round-robin search for the 16:1 mux scheduler.
// Latency: n/a (package). Backpressure: n/a.
// The search is purely combinational; callers register its result.
package mux16_sched_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit at or above ptr, wrapping 15->0. Scanning from the far end
    // lets the nearest match overwrite earlier ones without an early exit.
    function automatic rr_pick_t rr_find(input logic [NREQ-1:0]  req,
                                         input logic [SEL_W-1:0] ptr);
        rr_pick_t         pick;
        logic [SEL_W-1:0] j;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (req[j]) begin
                pick.found = 1'b1;
                pick.idx   = j;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux16to1.sv
// Plain 16:1 single-bit multiplexer.
// Latency: combinational. Backpressure: none.
// Select is expected to come straight from a register.
module mux16to1 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux; winner holds up to HOLD_MAX beats.
// Latency: grant one cycle after req seen in IDLE; out_bit combinational from data_in.
// Backpressure: out_valid holds with all state frozen until out_ready; one IDLE bubble per release.
module mux16_rr_sched
    import mux16_sched_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] beat_cnt
);

    localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0] beat_q, beat_d;
    rr_pick_t         pick;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        pick    = rr_find(req, ptr_q);
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    sel_d            = pick.idx;
                    grant_d          = '0;
                    grant_d[pick.idx] = 1'b1;
                    beat_d           = '0;
                    state_d          = GRANT;
                end
            end
            GRANT: begin
                // req is only looked at on a transfer, so a stalled beat always completes
                if (out_ready) begin
                    if (!req[sel_q] || beat_q == LAST_BEAT) begin
                        ptr_d   = sel_q + SEL_W'(1);
                        grant_d = '0;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

    assign out_valid = (state_q == GRANT);
    assign grant     = grant_q;
    assign sel       = sel_q;
    assign beat_cnt  = beat_q;

    mux16to1 u_mux (
        .in  (data_in),
        .sel (sel_q),
        .out (out_bit)
    );

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched: expected beats queued per grant, checked by a monitor.
module tb_mux16_rr_sched;

    localparam int HOLD_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] data_in;
    logic        out_ready;
    logic        out_valid;
    logic        out_bit;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic [3:0]  beat_cnt;

    always #5 clk = ~clk;

    mux16_rr_sched #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .grant     (grant),
        .sel       (sel),
        .beat_cnt  (beat_cnt)
    );

    typedef struct {
        int idx;
        int beat;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   ptr_m = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: nearest requester at or after the pointer, modulo 16.
    function automatic int rr_pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++)
            if (r[(p + k) % 16]) return (p + k) % 16;
        return -1;
    endfunction

    task automatic push_grant(input int idx, input int nbeats);
        for (int b = 0; b < nbeats; b++) sb.push_back('{idx, b});
        ptr_m = (idx + 1) % 16;
    endtask

    task automatic push_rr(input logic [15:0] r, input int ngrants);
        for (int g = 0; g < ngrants; g++) push_grant(rr_pick(r, ptr_m), HOLD_MAX);
    endtask

    task automatic drive_rand(input bit rand_ready, input bit rand_data);
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rand_data) data_in = 16'($urandom);
    endtask

    // Drive r0, switch to r1 after sw transfers, drop req after total transfers.
    task automatic run_seq(input logic [15:0] r0, input logic [15:0] r1, input int sw,
                           input int total, input bit rand_ready, input bit rand_data);
        int done = 0;
        int cyc  = 0;
        bit x;
        req = r0;
        drive_rand(rand_ready, rand_data);
        while (done < total && cyc < 500) begin
            @(negedge clk);
            x = out_valid && out_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (x) done++;
            if (done == sw) req = r1;
            if (done == total) req = '0;
            drive_rand(rand_ready, rand_data);
        end
        req = '0;
        chk("seq_done", done, total);
        last_cycles = cyc;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("grant_wait", out_valid, 1);
    endtask

    task automatic check_drained();
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        chk("idle_valid", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid) begin
                chk("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e_mon = sb[0];
                    chk("grant", grant, 32'(1) << e_mon.idx);
                    chk("sel", sel, e_mon.idx);
                    chk("beat_cnt", beat_cnt, e_mon.beat);
                    chk("out_bit", out_bit, data_in[e_mon.idx]);
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_grant", grant, 0);
                chk("idle_beat", beat_cnt, 0);
            end
        end
    end

    initial begin
        logic [15:0] r;
        int          n;
        rst_n     = 1'b1;
        req       = '0;
        data_in   = '0;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_beat", beat_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a stalled grant to requester 5
        sb.push_back('{5, 0});
        req = 16'h0020;
        out_ready = 1'b0;
        wait_valid();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_sel", sel, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_sel", sel, 0);
        chk("arst_beat", beat_cnt, 0);
        sb.delete();
        ptr_m = 0;
        req = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rotation: 0, 1, 15, 0 with full holds
        push_rr(16'h8003, 4);
        run_seq(16'h8003, 16'h8003, -1, 4 * HOLD_MAX, 1'b0, 1'b1);
        check_drained();
        @(posedge clk);
        #1;

        // Single requester, peak throughput HOLD_MAX beats per HOLD_MAX+1 cycles
        data_in = 16'h3f0a;
        push_rr(16'h0040, 2);
        run_seq(16'h0040, 16'h0040, -1, 2 * HOLD_MAX, 1'b0, 1'b0);
        chk("throughput_cycles", last_cycles, 2 * (HOLD_MAX + 1));
        check_drained();
        @(posedge clk);
        #1;

        // Back-pressure, then req drop during the stall: exactly one beat
        push_grant(12, 1);
        req = 16'h1000;
        out_ready = 1'b0;
        data_in = 16'($urandom);
        wait_valid();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        req = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_grant", grant, 0);
        check_drained();
        @(posedge clk);
        #1;

        // Early release of requester 0 after its second beat, then requester 8
        push_grant(0, 2);
        push_grant(8, HOLD_MAX);
        run_seq(16'h0101, 16'h0100, 1, 2 + HOLD_MAX, 1'b0, 1'b1);
        check_drained();
        @(posedge clk);
        #1;

        // Mux path: data_in[12] reaches out_bit with no clock edge
        push_grant(12, 1);
        req = 16'h1000;
        out_ready = 1'b0;
        data_in = 16'h3f0a;
        wait_valid();
        #1;
        chk("mux_bit_hi", out_bit, 1);
        data_in[12] = 1'b0;
        #1;
        chk("mux_bit_lo", out_bit, 0);
        data_in[12] = 1'b1;
        #1;
        chk("mux_bit_back", out_bit, 1);
        @(posedge clk);
        #1;
        req = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_drained();
        @(posedge clk);
        #1;

        // Random request patterns with random stalls and data
        for (int p = 0; p < 40; p++) begin
            r = 16'($urandom_range(1, 65535));
            n = $urandom_range(1, 4);
            push_rr(r, n);
            run_seq(r, r, -1, n * HOLD_MAX, 1'b1, 1'b1);
            check_drained();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
